// File: rtl/jpeg_bit_packer.sv
// JPEG scan bit packer: MSB-first codeword packing with 0xFF/0x00 stuffing.
// Ports: i_in_* codeword beat (valid/ready), o_out_* byte stream, o_flush_done.
`timescale 1ns/1ps
module jpeg_bit_packer #(
  parameter int CODE_W = 25,
  parameter int ACC_W  = 40,
  parameter int SIZE_W = $clog2(CODE_W + 1),
  parameter int CNT_W  = $clog2(ACC_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CODE_W-1:0] i_in_code,
  input  logic [SIZE_W-1:0] i_in_size,
  input  logic              i_in_flush,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [7:0]        o_out_byte,
  output logic              o_flush_done
);

  typedef enum logic [1:0] {
    S_RUN,
    S_STUFF,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             r_ret;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [7:0]         r_out_byte;

  state_t             w_nxt_state;
  state_t             w_nxt_ret;
  state_t             w_post;
  logic [ACC_W-1:0]   w_nxt_acc;
  logic [CNT_W-1:0]   w_nxt_cnt;
  logic [CNT_W-1:0]   w_add;
  logic [CNT_W-1:0]   w_dec;
  logic               w_accept;
  logic               w_slot_free;
  logic               w_load;
  logic [7:0]         w_byte;
  logic [7:0]         w_top;
  logic [7:0]         w_pad;
  logic [CODE_W-1:0]  w_mask;
  logic [CODE_W-1:0]  w_code;
  logic [ACC_W-1:0]   w_acc_in;

  assign o_in_ready   = !i_rst && (r_state == S_RUN)
                     && (r_cnt <= CNT_W'(ACC_W - CODE_W));
  assign o_out_valid  = r_out_valid;
  assign o_out_byte   = r_out_byte;
  assign o_flush_done = !i_rst && (r_state == S_DONE);

  assign w_accept    = i_in_valid && o_in_ready;
  assign w_slot_free = !r_out_valid || i_out_ready;

  // Bits above in_size are don't-care on the input.
  assign w_mask   = {CODE_W{1'b1}} >> (SIZE_W'(CODE_W) - i_in_size);
  assign w_code   = i_in_code & w_mask;
  assign w_acc_in = (r_acc << i_in_size) | ACC_W'(w_code);
  assign w_add    = w_accept ? CNT_W'(i_in_size) : '0;

  // Valid bits sit right-aligned; the oldest is at bit cnt-1.
  assign w_top = 8'(r_acc >> (r_cnt - CNT_W'(8)));
  assign w_pad = 8'(r_acc << (CNT_W'(8) - r_cnt)) | (8'hFF >> r_cnt);

  // State after any accept this cycle; a stuff byte returns here.
  assign w_post = (w_accept && i_in_flush) ? S_FLUSH : r_state;

  always_comb begin
    w_nxt_state = w_post;
    w_nxt_ret   = r_ret;
    w_load      = 1'b0;
    w_byte      = 8'h00;
    w_dec       = '0;
    if (r_state == S_DONE) begin
      w_nxt_state = S_RUN;
    end else if (w_slot_free) begin
      priority case (1'b1)
        r_state == S_STUFF: begin
          w_load      = 1'b1;
          w_nxt_state = r_ret;
        end
        r_cnt >= CNT_W'(8): begin
          w_load = 1'b1;
          w_byte = w_top;
          w_dec  = CNT_W'(8);
        end
        (r_state == S_FLUSH) && (r_cnt != '0): begin
          w_load = 1'b1;
          w_byte = w_pad;
          w_dec  = r_cnt;
        end
        r_state == S_FLUSH: begin
          w_nxt_state = S_DONE;
        end
        default: begin
        end
      endcase
      if (w_load && (w_byte == 8'hFF)) begin
        w_nxt_state = S_STUFF;
        w_nxt_ret   = w_post;
      end
    end
  end

  always_comb begin
    w_nxt_acc = w_accept ? w_acc_in : r_acc;
    w_nxt_cnt = r_cnt + w_add - w_dec;
    if (r_state == S_DONE) begin
      w_nxt_acc = '0;
      w_nxt_cnt = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_RUN;
      r_ret       <= S_RUN;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
    end else begin
      r_state <= w_nxt_state;
      r_ret   <= w_nxt_ret;
      r_acc   <= w_nxt_acc;
      r_cnt   <= w_nxt_cnt;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_byte  <= w_byte;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Self-checking bench for jpeg_bit_packer.
// Reference: bit queue, 1-padding on flush, 0x00 after each 0xFF.
`timescale 1ns/1ps
module tb_jpeg_bit_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [24:0] in_code = '0;
  logic [4:0]  in_size = '0;
  logic        in_flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic        flush_done;

  int n_cmp = 0;
  int n_fail = 0;
  int fd_n = 0;
  int fd_at = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  bit         mbits[$];
  bit         hold_prev = 1'b0;
  logic [7:0] prev_byte = '0;

  jpeg_bit_packer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_in_code    (in_code),
    .i_in_size    (in_size),
    .i_in_flush   (in_flush),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_byte   (out_byte),
    .o_flush_done (flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic mpush(input logic [24:0] c, input int s, input bit f);
    logic [7:0] b;
    for (int i = s - 1; i >= 0; i--) mbits.push_back(c[i]);
    if (f) while (mbits.size() % 8 != 0) mbits.push_back(1'b1);
    while (mbits.size() >= 8) begin
      b = '0;
      for (int j = 0; j < 8; j++) b = {b[6:0], mbits.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [24:0] c, input int s, input bit f);
    int k;
    in_valid = 1'b1;
    in_code  = c;
    in_size  = 5'(s);
    in_flush = f;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
    in_code  = 25'($urandom);
    in_size  = 5'($urandom);
    mpush(c, s, f);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk(tag, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    got.delete();
    exp_q.delete();
    mbits.delete();
    fd_n = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_byte", 32'(out_byte), 32'(prev_byte));
      end
      if (out_valid && out_ready) got.push_back(out_byte);
      hold_prev <= out_valid && !out_ready;
      prev_byte <= out_byte;
      if (flush_done) begin
        fd_n  <= fd_n + 1;
        fd_at <= got.size();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_byte", 32'(out_byte), 32'd0);
    chk("rst_fd", 32'(flush_done), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // two codes forming one byte; garbage above size
    send({22'($urandom), 3'b101}, 3, 1'b0);
    send({20'($urandom), 5'b11111}, 5, 1'b0);
    cycles(8);
    chk("t1_exp", 32'(exp_q.size()), 32'd1);
    cmp_stream("t1_bytes");

    // FF then 12: stuff byte inserted
    send({17'($urandom), 8'hFF}, 8, 1'b0);
    send({17'($urandom), 8'h12}, 8, 1'b0);
    @(negedge clk);
    chk("t2_v0", 32'(out_valid), 32'd1);
    chk("t2_b0", 32'(out_byte), 32'hFF);
    @(negedge clk);
    chk("t2_b1", 32'(out_byte), 32'h00);
    @(negedge clk);
    chk("t2_b2", 32'(out_byte), 32'h12);
    @(negedge clk);
    chk("t2_v3", 32'(out_valid), 32'd0);
    cycles(4);
    cmp_stream("t2_bytes");

    // flush with 1-bit partial byte
    fd_n = 0;
    send(25'h0, 1, 1'b1);
    cycles(10);
    chk("t3a_fd_n", 32'(fd_n), 32'd1);
    chk("t3a_fd_at", 32'(fd_at), 32'(exp_q.size()));
    cmp_stream("t3a_bytes");

    // flush ending in FF: stuff precedes flush_done
    fd_n = 0;
    send({21'($urandom), 4'b1111}, 4, 1'b1);
    cycles(10);
    chk("t3b_fd_n", 32'(fd_n), 32'd1);
    chk("t3b_fd_at", 32'(fd_at), 32'd2);
    cmp_stream("t3b_bytes");

    // empty flush: flush_done at N+2
    fd_n = 0;
    send(25'($urandom), 0, 1'b1);
    @(negedge clk);
    chk("t4_fd_n1", 32'(flush_done), 32'd0);
    chk("t4_rdy_n1", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t4_fd_n2", 32'(flush_done), 32'd1);
    chk("t4_v_n2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t4_fd_n3", 32'(flush_done), 32'd0);
    chk("t4_rdy_n3", 32'(in_ready), 32'd1);
    cycles(2);
    chk("t4_fd_cnt", 32'(fd_n), 32'd1);
    cmp_stream("t4_bytes");

    // random 25-bit codes under backpressure
    fork
      begin
        for (int i = 0; i < 10; i++) send(25'($urandom), 25, 1'b0);
      end
      begin
        out_ready = 1'b0;
        cycles(10);
        @(negedge clk);
        chk("t5_stall_rdy", 32'(in_ready), 32'd0);
        chk("t5_stall_v", 32'(out_valid), 32'd1);
        cycles(2);
        repeat (400) begin
          out_ready = 1'($urandom);
          cycles(1);
        end
        out_ready = 1'b1;
      end
    join
    cycles(20);
    cmp_stream("t5_bytes");

    // reset mid-operation with a held byte and cnt=13
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    clear_model();
    out_ready = 1'b0;
    send(25'($urandom), 21, 1'b0);
    cycles(4);
    @(negedge clk);
    chk("t6_pre_v", 32'(out_valid), 32'd1);
    chk("t6_pre_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_v", 32'(out_valid), 32'd0);
    chk("t6_post_rdy", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    clear_model();
    out_ready = 1'b1;
    send(25'h0000A5, 8, 1'b0);
    cycles(8);
    chk("t6_exp", 32'(exp_q.size()), 32'd1);
    cmp_stream("t6_bytes");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
